uart_rx_monitor: RTL and testbench

Simulation-side serial receiver sitting directly downstream of the CPU top's `Tx` pin in the testbench. Deserializes 8N1 UART frames, buffers received bytes in a small FIFO, and presents them on a valid/ready byte stream for the bench to print or compare. Also counts bytes and flags framing errors and FIFO overflow, so program-output checks need no waveform inspection.

---
 rtl/uart_pkg.sv | 17 +
 rtl/uart_rx_fifo.sv | 53 +++++
 rtl/uart_rx_monitor.sv | 197 +++++++++++++++++++
 tb/tb_uart_rx_monitor.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive monitor.
// Build option: UART_RX_PARITY_EN selects 8E1 framing (default 8N1).
package uart_pkg;

    localparam int unsigned UART_DATA_BITS            = 8;
    localparam int unsigned UART_CLKS_PER_BIT_DEFAULT = 868;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_PARITY    = 3'd3,
        ST_STOP      = 3'd4,
        ST_WAIT_IDLE = 3'd5
    } uart_rx_state_e;

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous receive FIFO; pointers carry an extra wrap bit to split full from empty.
module uart_rx_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             empty,
    output logic             full
);

    localparam int unsigned ADDR_W = $clog2(DEPTH);
    localparam int unsigned PTR_W  = ADDR_W + 1;

    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [WIDTH-1:0] r_mem [DEPTH];

    logic w_pop;
    logic w_push;

    assign empty     = (r_wr_ptr == r_rd_ptr);
    assign full      = (r_wr_ptr[ADDR_W] != r_rd_ptr[ADDR_W]) &&
                       (r_wr_ptr[ADDR_W-1:0] == r_rd_ptr[ADDR_W-1:0]);
    assign w_pop     = pop && !empty;
    // A pop in the same cycle frees the slot the write needs.
    assign w_push    = push && (!full || w_pop);
    assign head_data = r_mem[r_rd_ptr[ADDR_W-1:0]];

    // Pointer and storage update; storage resets so the head reads 0 after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr[ADDR_W-1:0]] <= push_data;
                r_wr_ptr                    <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_rx_monitor.sv
// UART receive monitor: 8N1 deserializer feeding a byte FIFO on a valid/ready stream,
// with byte counting and framing-error / overflow pulses.
// Build option: UART_RX_PARITY_EN adds an even-parity bit (8E1).
module uart_rx_monitor
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT_DEFAULT,
    parameter int unsigned FIFO_DEPTH   = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      rx,
    output logic [UART_DATA_BITS-1:0] out_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      frame_err,
    output logic                      overflow,
    output logic [31:0]               byte_count
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned BIT_W = $clog2(UART_DATA_BITS);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(UART_DATA_BITS - 1);

    logic                      r_rx_meta;
    logic                      r_rx_s;
    uart_rx_state_e            r_state;
    logic [CNT_W-1:0]          r_cnt;
    logic [BIT_W-1:0]          r_bit_idx;
    logic [UART_DATA_BITS-1:0] r_shift;
    logic                      r_frame_err;
    logic                      r_overflow;
    logic [31:0]               r_byte_count;

    uart_rx_state_e            w_state_nxt;
    logic [CNT_W-1:0]          w_cnt_nxt;
    logic [BIT_W-1:0]          w_bit_nxt;
    logic [UART_DATA_BITS-1:0] w_shift_nxt;
    logic                      w_push_c;
    logic                      w_ferr_nxt;
    logic                      w_tick_full;
    logic                      w_par_err;
    logic                      w_fifo_empty;
    logic                      w_fifo_full;
    logic                      w_pop;
    logic                      w_accept;
    logic [UART_DATA_BITS-1:0] w_head;

`ifdef UART_RX_PARITY_EN
    logic r_par_bit;
    logic w_par_nxt;
    // Even parity over data plus parity bit must come out zero.
    assign w_par_err = ^{r_shift, r_par_bit};
`else
    assign w_par_err = 1'b0;
`endif

    assign w_tick_full = (r_cnt == CNT_FULL);
    assign out_valid   = ~w_fifo_empty;
    assign out_data    = w_head;
    assign w_pop       = out_valid && out_ready;
    assign w_accept    = w_push_c && (!w_fifo_full || w_pop);
    assign frame_err   = r_frame_err;
    assign overflow    = r_overflow;
    assign byte_count  = r_byte_count;

    // Two-flop synchronizer for the asynchronous serial line (idles high).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_s    <= r_rx_meta;
        end
    end

    // Receiver state, bit timing and status registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_bit_idx    <= '0;
            r_shift      <= '0;
            r_frame_err  <= 1'b0;
            r_overflow   <= 1'b0;
            r_byte_count <= '0;
`ifdef UART_RX_PARITY_EN
            r_par_bit    <= 1'b0;
`endif
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_bit_idx    <= w_bit_nxt;
            r_shift      <= w_shift_nxt;
            r_frame_err  <= w_ferr_nxt;
            r_overflow   <= w_push_c && !w_accept;
            r_byte_count <= r_byte_count + 32'(w_accept);
`ifdef UART_RX_PARITY_EN
            r_par_bit    <= w_par_nxt;
`endif
        end
    end

    // Next-state logic: start qualification, mid-bit sampling, stop check.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + 1'b1;
        w_bit_nxt   = r_bit_idx;
        w_shift_nxt = r_shift;
        w_push_c    = 1'b0;
        w_ferr_nxt  = 1'b0;
`ifdef UART_RX_PARITY_EN
        w_par_nxt   = r_par_bit;
`endif
        case (r_state)
            ST_IDLE: begin
                w_cnt_nxt = '0;
                if (!r_rx_s) begin
                    w_state_nxt = ST_START;
                end
            end
            ST_START: begin
                if (r_cnt == CNT_HALF) begin
                    w_cnt_nxt   = '0;
                    w_bit_nxt   = '0;
                    // Line back high at mid-start: a glitch, not a frame.
                    w_state_nxt = r_rx_s ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_tick_full) begin
                    w_cnt_nxt   = '0;
                    w_shift_nxt = {r_rx_s, r_shift[UART_DATA_BITS-1:1]};
                    if (r_bit_idx == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                        w_state_nxt = ST_PARITY;
`else
                        w_state_nxt = ST_STOP;
`endif
                    end else begin
                        w_bit_nxt = r_bit_idx + 1'b1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (w_tick_full) begin
                    w_cnt_nxt   = '0;
                    w_par_nxt   = r_rx_s;
                    w_state_nxt = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (w_tick_full) begin
                    w_cnt_nxt = '0;
                    if (r_rx_s && !w_par_err) begin
                        w_push_c    = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_ferr_nxt  = 1'b1;
                        w_state_nxt = ST_WAIT_IDLE;
                    end
                end
            end
            ST_WAIT_IDLE: begin
                // Hold off while the line stays low so a break is not read as 0x00 frames.
                w_cnt_nxt = '0;
                if (r_rx_s) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_cnt_nxt   = '0;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    uart_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (UART_DATA_BITS)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (w_push_c),
        .push_data (w_shift_nxt),
        .pop       (w_pop),
        .head_data (w_head),
        .empty     (w_fifo_empty),
        .full      (w_fifo_full)
    );

endmodule

// File: tb/tb_uart_rx_monitor.sv
// Bench for uart_rx_monitor at CLKS_PER_BIT = 8, FIFO_DEPTH = 16.
// Build option: UART_RX_PARITY_EN drives 8E1 frames and adds parity cases.
module tb_uart_rx_monitor;

    localparam int unsigned CPB   = 8;
    localparam int unsigned DEPTH = 16;
`ifdef UART_RX_PARITY_EN
    localparam int unsigned FRAME_BITS = 11;
`else
    localparam int unsigned FRAME_BITS = 10;
`endif
    // Edges from the start-bit drive edge to the edge that writes the byte:
    // 2 sync + 1 IDLE detect, half bit in START, then one bit time per remaining bit.
    localparam int unsigned STOP_EDGE = 3 + CPB / 2 + CPB * (FRAME_BITS - 1);

    logic        clk;
    logic        rst_n;
    logic        rx;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic        frame_err;
    logic        overflow;
    logic [31:0] byte_count;

    int n_checks;
    int n_errors;
    int n_ferr;
    int n_ovf;
    logic prev_ferr;
    logic prev_ovf;
    logic [7:0] exp_q[$];

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic       bad_par;
        logic       exp_ok;
    } vec_t;
    vec_t tbl[$];

    uart_rx_monitor #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx         (rx),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .frame_err  (frame_err),
        .overflow   (overflow),
        .byte_count (byte_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: every accepted handshake must match the oldest expected byte.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_errors++;
                $display("FAIL sb_unexpected: got byte 0x%0h with nothing expected", out_data);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (out_data !== e) begin
                    n_errors++;
                    $display("FAIL sb_data: got 0x%0h, expected 0x%0h", out_data, e);
                end
            end
        end
    end

    // Flag pulse counters; each pulse must last exactly one cycle.
    always @(negedge clk) begin
        if (frame_err) begin
            n_ferr++;
            n_checks++;
            if (prev_ferr) begin
                n_errors++;
                $display("FAIL ferr_width: got 2+ cycle pulse, expected 1");
            end
        end
        if (overflow) begin
            n_ovf++;
            n_checks++;
            if (prev_ovf) begin
                n_errors++;
                $display("FAIL ovf_width: got 2+ cycle pulse, expected 1");
            end
        end
        prev_ferr = frame_err;
        prev_ovf  = overflow;
    end

    initial begin
        #5000000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    task automatic send_frame(input logic [7:0] d, input logic stop, input logic bad_par);
        @(posedge clk);
        #1 rx = 1'b0;
        repeat (CPB) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            #1 rx = d[i];
            repeat (CPB) @(posedge clk);
        end
`ifdef UART_RX_PARITY_EN
        #1 rx = (^d) ^ bad_par;
        repeat (CPB) @(posedge clk);
`else
        if (bad_par) $display("note: parity request ignored in 8N1 build");
`endif
        #1 rx = stop;
        repeat (CPB) @(posedge clk);
        #1 rx = 1'b1;
        repeat (4) @(posedge clk);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst_n = 1'b0;
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
    endtask

    task automatic drain(input string name);
        int guard;
        @(posedge clk);
        #1 out_ready = 1'b1;
        guard = 0;
        while ((exp_q.size() != 0 || out_valid) && guard < 200) begin
            @(posedge clk);
            guard++;
        end
        @(negedge clk);
        check({name, "_q_empty"}, 32'(exp_q.size()), 32'd0);
        check({name, "_valid_low"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        int base_f;
        int base_o;
        logic [31:0] base_c;

        n_checks  = 0;
        n_errors  = 0;
        n_ferr    = 0;
        n_ovf     = 0;
        prev_ferr = 1'b0;
        prev_ovf  = 1'b0;
        rst_n     = 1'b0;
        rx        = 1'b1;
        out_ready = 1'b0;

        // Reset values.
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_data", 32'(out_data), 32'h00);
        check("rst_ferr", 32'(frame_err), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        check("rst_count", byte_count, 32'd0);
        #1 rst_n = 1'b1;
        repeat (3) @(posedge clk);

        // 0x41: exact out_valid timing after the stop sample.
        exp_q.push_back(8'h41);
        fork
            send_frame(8'h41, 1'b1, 1'b0);
            begin
                @(posedge clk);
                repeat (STOP_EDGE - 1) @(posedge clk);
                @(negedge clk);
                check("t41_valid_before", 32'(out_valid), 32'd0);
                @(posedge clk);
                @(negedge clk);
                check("t41_valid_after", 32'(out_valid), 32'd1);
                check("t41_data", 32'(out_data), 32'h41);
                check("t41_count", byte_count, 32'd1);
            end
        join
        drain("t41");

        // Start glitch: low for 3 cycles only.
        base_f = n_ferr;
        base_c = byte_count;
        @(posedge clk);
        #1 rx = 1'b0;
        repeat (3) @(posedge clk);
        #1 rx = 1'b1;
        repeat (30) @(posedge clk);
        @(negedge clk);
        check("glitch_ferr", 32'(n_ferr - base_f), 32'd0);
        check("glitch_count", byte_count, base_c);
        check("glitch_valid", 32'(out_valid), 32'd0);

        // Bad stop then break (line low 40 cycles), then a good frame.
        base_f = n_ferr;
        base_c = byte_count;
        @(posedge clk);
        #1 rx = 1'b0;
        repeat (CPB) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            #1 rx = 8'h55 >> i;
            repeat (CPB) @(posedge clk);
        end
`ifdef UART_RX_PARITY_EN
        #1 rx = ^8'h55;
        repeat (CPB) @(posedge clk);
`endif
        #1 rx = 1'b0;
        repeat (CPB + 40) @(posedge clk);
        #1 rx = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("break_ferr", 32'(n_ferr - base_f), 32'd1);
        check("break_count", byte_count, base_c);
        exp_q.push_back(8'h0A);
        send_frame(8'h0A, 1'b1, 1'b0);
        @(negedge clk);
        check("after_break_count", byte_count, base_c + 32'd1);
        drain("after_break");

        // Table of single frames, consumer always ready.
        tbl.push_back('{8'hFF, 1'b1, 1'b0, 1'b1});
        tbl.push_back('{8'h00, 1'b1, 1'b0, 1'b1});
        tbl.push_back('{8'h80, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{8'hA5, 1'b1, 1'b0, 1'b1});
        tbl.push_back('{8'h5A, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{8'h01, 1'b1, 1'b0, 1'b1});
`ifdef UART_RX_PARITY_EN
        tbl.push_back('{8'h03, 1'b1, 1'b1, 1'b0});
        tbl.push_back('{8'h03, 1'b1, 1'b0, 1'b1});
        tbl.push_back('{8'h07, 1'b1, 1'b1, 1'b0});
`endif
        out_ready = 1'b1;
        for (int k = 0; k < tbl.size(); k++) begin
            base_f = n_ferr;
            base_c = byte_count;
            if (tbl[k].exp_ok) exp_q.push_back(tbl[k].data);
            send_frame(tbl[k].data, tbl[k].stop, tbl[k].bad_par);
            repeat (4) @(posedge clk);
            @(negedge clk);
            check($sformatf("tbl%0d_ferr", k), 32'(n_ferr - base_f), 32'(!tbl[k].exp_ok));
            check($sformatf("tbl%0d_count", k), byte_count - base_c, 32'(tbl[k].exp_ok));
        end
        drain("tbl");

        // Overflow: 17 bytes with the consumer stalled.
        do_reset();
        #1 out_ready = 1'b0;
        base_o = n_ovf;
        for (int k = 0; k <= 16; k++) begin
            if (k < 16) exp_q.push_back(8'(k));
            send_frame(8'(k), 1'b1, 1'b0);
            if (k == 15) begin
                @(negedge clk);
                check("ovf_none_at_16", 32'(n_ovf - base_o), 32'd0);
            end
        end
        @(negedge clk);
        check("ovf_pulse", 32'(n_ovf - base_o), 32'd1);
        check("ovf_count", byte_count, 32'd16);
        check("ovf_head_stable", 32'(out_data), 32'h00);
        check("ovf_valid", 32'(out_valid), 32'd1);
        drain("ovf");

        // Full FIFO with a pop landing on the 17th stop sample.
        do_reset();
        #1 out_ready = 1'b0;
        base_o = n_ovf;
        for (int k = 0; k < 16; k++) begin
            exp_q.push_back(8'(8'h20 + k));
            send_frame(8'(8'h20 + k), 1'b1, 1'b0);
        end
        exp_q.push_back(8'hC3);
        fork
            send_frame(8'hC3, 1'b1, 1'b0);
            begin
                @(posedge clk);
                repeat (STOP_EDGE - 1) @(posedge clk);
                #1 out_ready = 1'b1;
                @(posedge clk);
                #1 out_ready = 1'b0;
            end
        join
        @(negedge clk);
        check("coinc_ovf", 32'(n_ovf - base_o), 32'd0);
        check("coinc_count", byte_count, 32'd17);
        drain("coinc");

        // Reset asserted mid-DATA with a byte buffered; line stays low afterwards.
        #1 out_ready = 1'b0;
        exp_q.push_back(8'h77);
        send_frame(8'h77, 1'b1, 1'b0);
        @(posedge clk);
        #1 rx = 1'b0;
        repeat (20) @(posedge clk);
        #1 rst_n = 1'b0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_data", 32'(out_data), 32'h00);
        check("mid_rst_count", byte_count, 32'd0);
        check("mid_rst_ferr", 32'(frame_err), 32'd0);
        check("mid_rst_ovf", 32'(overflow), 32'd0);
        base_f = n_ferr;
        #1 rst_n = 1'b1;
        repeat (CPB * FRAME_BITS + 20) @(posedge clk);
        #1 rx = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("post_rst_ferr", 32'(n_ferr - base_f), 32'd1);
        check("post_rst_count", byte_count, 32'd0);
        check("post_rst_valid", 32'(out_valid), 32'd0);
        exp_q.push_back(8'h3C);
        out_ready = 1'b1;
        send_frame(8'h3C, 1'b1, 1'b0);
        drain("post_rst");
        check("post_rst_final_count", byte_count, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
